// File: rtl/multdiv_sequencer.sv
// multdiv_sequencer: execute-stage controller for the shared multi-cycle
// multdiv unit. It latches operands, fires one start pulse, holds the
// pipeline stall while the unit works (bounded by a timeout) and then
// presents the result or the $rstatus error code for exactly one cycle.
module multdiv_sequencer #(
  parameter int WIDTH      = 32,
  parameter int MAX_CYCLES = 40,
  parameter int CNT_W      = 6,
  parameter int MUL_ERR    = 4,
  parameter int DIV_ERR    = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             x_is_mul,
  input  logic             x_is_div,
  input  logic             flush,
  input  logic [WIDTH-1:0] x_opA,
  input  logic [WIDTH-1:0] x_opB,
  output logic             md_ctrl_MULT,
  output logic             md_ctrl_DIV,
  output logic [WIDTH-1:0] md_operandA,
  output logic [WIDTH-1:0] md_operandB,
  input  logic [WIDTH-1:0] md_result,
  input  logic             md_exception,
  input  logic             md_resultRDY,
  output logic             stall,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  output logic             res_exc
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_BUSY  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);

  // Error code written to $rstatus depends on which operation failed.
  function automatic logic [WIDTH-1:0] err_code(input logic is_mul);
    logic [WIDTH-1:0] code;
    if (is_mul) begin
      code = WIDTH'(MUL_ERR);
    end else begin
      code = WIDTH'(DIV_ERR);
    end
    return code;
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             is_mul_q, is_mul_d;
  logic             mult_q, mult_d;
  logic             div_q, div_d;
  logic             valid_q, valid_d;
  logic             exc_q, exc_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             req_s;

  // A request is any mul/div in X that is not being squashed.
  assign req_s = (x_is_mul | x_is_div) & ~flush;

  // Next-state and output decode; every output is taken from a register so
  // the start pulse and the result strobe are glitch-free single cycles.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    is_mul_d = is_mul_q;
    mult_d   = 1'b0;
    div_d    = 1'b0;
    valid_d  = 1'b0;
    exc_d    = exc_q;
    data_d   = data_q;
    case (state_q)
      ST_IDLE: begin
        if (req_s) begin
          // mul wins when both decode lines are high
          state_d  = ST_START;
          opa_d    = x_opA;
          opb_d    = x_opB;
          is_mul_d = x_is_mul;
          mult_d   = x_is_mul;
          div_d    = ~x_is_mul;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        // RDY/exception may be stale from a previous op here, so ignore them
        cnt_d = {CNT_W{1'b0}};
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (flush) begin
          state_d = ST_IDLE;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          if (md_exception) begin
            state_d = ST_DONE;
            valid_d = 1'b1;
            exc_d   = 1'b1;
            data_d  = err_code(is_mul_q);
          end else if (md_resultRDY) begin
            state_d = ST_DONE;
            valid_d = 1'b1;
            exc_d   = 1'b0;
            data_d  = md_result;
          end else if (cnt_q == CNT_LAST) begin
            // unit never answered: report it as an exception of this op
            state_d = ST_DONE;
            valid_d = 1'b1;
            exc_d   = 1'b1;
            data_d  = err_code(is_mul_q);
          end else begin
            state_d = ST_BUSY;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = {CNT_W{1'b0}};
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      opa_q    <= {WIDTH{1'b0}};
      opb_q    <= {WIDTH{1'b0}};
      is_mul_q <= 1'b0;
      mult_q   <= 1'b0;
      div_q    <= 1'b0;
      valid_q  <= 1'b0;
      exc_q    <= 1'b0;
      data_q   <= {WIDTH{1'b0}};
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      is_mul_q <= is_mul_d;
      mult_q   <= mult_d;
      div_q    <= div_d;
      valid_q  <= valid_d;
      exc_q    <= exc_d;
      data_q   <= data_d;
    end
  end

  // Stall covers the request cycle plus START/BUSY; DONE lets X advance.
  assign stall = ~reset & (((state_q == ST_IDLE) & req_s) |
                           (state_q == ST_START) |
                           (state_q == ST_BUSY));

  assign md_ctrl_MULT = mult_q;
  assign md_ctrl_DIV  = div_q;
  assign md_operandA  = opa_q;
  assign md_operandB  = opb_q;
  assign res_valid    = valid_q;
  assign res_data     = data_q;
  assign res_exc      = exc_q;

endmodule

// File: doc/multdiv_sequencer.md
Name: multdiv_sequencer

Overview:
- Execute-stage controller that sequences the shared multi-cycle multdiv unit for `mul` and `div`.
- On each request it:
  - captures the operands and issues exactly one single-cycle start pulse;
  - holds the pipeline stall until the result is ready, an exception occurs, or a timeout expires;
  - presents the result, or the $rstatus error code, for one cycle.
- Replaces ad-hoc pulse generation and stall logic in the processor; sits between the X-stage decode signals and the multdiv instance.

Parameters:
- WIDTH, 32, datapath width of operands and result.
- MAX_CYCLES, 40, cycles allowed in BUSY before a forced timeout exception.
- CNT_W, 6, cycle-counter width; must satisfy 2^CNT_W > MAX_CYCLES.
- MUL_ERR, 4, error code written to $rstatus on a mul exception or timeout.
- DIV_ERR, 5, error code written to $rstatus on a div exception or timeout.

Ports:
- clock  in  1  master clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- x_is_mul  in  1  X-stage instruction is `mul`.
- x_is_div  in  1  X-stage instruction is `div`.
- flush  in  1  X-stage instruction is being squashed (branch/jump); aborts the operation.
- x_opA  in  WIDTH  bypassed operand A.
- x_opB  in  WIDTH  bypassed operand B.
- md_ctrl_MULT  out  1  start-multiply pulse to the multdiv unit.
- md_ctrl_DIV  out  1  start-divide pulse to the multdiv unit.
- md_operandA  out  WIDTH  latched operand A to the multdiv unit.
- md_operandB  out  WIDTH  latched operand B to the multdiv unit.
- md_result  in  WIDTH  multdiv result.
- md_exception  in  1  multdiv exception (overflow or divide by zero).
- md_resultRDY  in  1  multdiv result ready.
- stall  out  1  freeze PC and all pipeline latches.
- res_valid  out  1  result/exception presented this cycle; X stage advances.
- res_data  out  WIDTH  result, or the error code when res_exc=1.
- res_exc  out  1  exception; X stage must convert the instruction to a write of $r30.

Behaviour:
- States: IDLE, START, BUSY, DONE. Encoding is 2 bits, registered.
- Request: req = (x_is_mul | x_is_div) & ~flush. If both are high, mul wins.

Reset:
- Asynchronous.
- state=IDLE, counter=0, operand registers=0, op flag=0, md_ctrl_*=0, res_valid=0, res_exc=0, res_data=0.
- stall is combinational: 0 while reset is high.

Transitions:
- IDLE:
  - req → START; latch x_opA, x_opB and op type (mul/div).
  - Otherwise stay in IDLE.
- START:
  - md_ctrl_MULT or md_ctrl_DIV = 1 for this cycle only, driven from a register, never from a comb decode.
  - counter ← 0; → BUSY.
  - md_resultRDY and md_exception are ignored in START, since they may be stale from a prior op.
- BUSY:
  - counter += 1 each cycle.
  - md_exception → DONE with exc=1.
  - Else md_resultRDY → DONE with exc=0; capture md_result.
  - Else counter == MAX_CYCLES-1 → DONE with exc=1 (timeout).
  - If exception and RDY arrive in the same cycle, exception wins.
- DONE:
  - res_valid=1 for exactly one cycle, with res_data/res_exc registered.
  - res_data = MUL_ERR or DIV_ERR when exc=1.
  - → IDLE.

Stall and operand rules:
- stall = (state==IDLE & req) | state==START | state==BUSY.
- stall=0 in DONE, so the instruction leaves X at the end of DONE.
- Back-to-back ops: a new req in the IDLE cycle after DONE starts a fresh sequence. There are no idle gaps beyond that single IDLE cycle.
- md_operandA/B are held constant from START through DONE, independent of the pipeline operands.

Flush and abort:
- flush in START or BUSY → IDLE next edge. No res_valid, counter cleared.
- The in-flight unit result is discarded; the next START pulse restarts the unit.
- flush in DONE: res_valid is still asserted, and the consumer gates it with flush.

Latency:
- A multdiv that raises RDY k cycles after the start pulse gives a stall of k+2 cycles: IDLE-with-req, START, then k BUSY cycles.
- res_valid follows one cycle after RDY.

Mid-operation reset: returns to IDLE immediately with all outputs cleared.

Test Plan:
- Mul: A=7, B=-6, unit RDY 4 cycles after pulse → exactly one md_ctrl_MULT pulse; stall high 6 cycles; res_valid one cycle with res_data=-42, res_exc=0.
- Div by zero: A=10, B=0, md_exception at BUSY cycle 2 → res_valid=1, res_exc=1, res_data=5; no md_ctrl_MULT ever asserted.
- Timeout: unit never asserts RDY, MAX_CYCLES=40 → DONE entered after 40 BUSY cycles; res_exc=1, res_data=4 for mul.
- Flush: flush pulsed in BUSY cycle 3 → IDLE next edge, stall drops, res_valid never asserts; the next div request issues a new md_ctrl_DIV pulse.
- Back-to-back mul then div: two distinct single-cycle pulses with a correct op each; operands are held across the first op even when x_opA changes mid-BUSY.
- Async reset asserted in BUSY between clock edges → state=IDLE and stall=0 immediately; after release, IDLE with no spurious pulse.
